// File: rtl/fi_chain_reader.sv
// rtl/fi_chain_reader.sv - fault-injection scan chain capture with word FIFO and register window
module fi_chain_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        i_CLK_SYS,
    input  logic        i_RST_SYS,
    input  logic        i_SO,
    input  logic        i_EN_SR,
    input  logic [31:0] i_ADDR,
    input  logic        i_WREn,
    input  logic        i_RDEn,
    input  logic [31:0] i_WRDATA,
    output logic [31:0] o_RDATA,
    output logic        o_IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t      state;
    logic        irq_en;
    logic        ovf;
    logic [31:0] sr;
    logic [4:0]  cnt;
    logic [31:0] bitcnt;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] mem [FIFO_DEPTH];

    logic        sel_ctrl, sel_status, sel_data, sel_bitcnt;
    logic        wr_ctrl, clr, flush, shift;
    logic [31:0] sr_shift;
    logic [4:0]  cnt_next;
    logic        push, push_ok, pop, empty, full;
    logic [AW:0] level;
    logic [31:0] rd_mux;

    // Only CTRL bits [3:0] carry meaning; the rest of the write data is dropped
    logic unused_wrdata;
    assign unused_wrdata = ^i_WRDATA[31:4];

    assign sel_ctrl   = (i_ADDR == BASE_ADDR);
    assign sel_status = (i_ADDR == BASE_ADDR + 32'h4);
    assign sel_data   = (i_ADDR == BASE_ADDR + 32'h8);
    assign sel_bitcnt = (i_ADDR == BASE_ADDR + 32'hC);

    assign wr_ctrl = i_WREn && sel_ctrl;
    assign clr     = wr_ctrl && i_WRDATA[1];
    assign flush   = wr_ctrl && i_WRDATA[2];
    assign shift   = (state == CAPTURE) && i_EN_SR;

    // A flush landing on a shift cycle includes that cycle's bit; a wrap is a normal full-word push
    assign sr_shift = shift ? {i_SO, sr[31:1]} : sr;
    assign cnt_next = shift ? cnt + 5'd1 : cnt;
    assign push     = (shift && cnt == 5'd31) || (flush && cnt_next != 5'd0);

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign pop     = i_RDEn && sel_data && !empty;
    assign push_ok = push && (!full || pop);

    assign o_IRQ = irq_en && !empty;

    // Read mux over pre-write state so a simultaneous write is not visible to the read
    always_comb begin
        rd_mux = '0;
        if (sel_ctrl) begin
            rd_mux[0] = (state == CAPTURE);
            rd_mux[3] = irq_en;
        end else if (sel_status) begin
            rd_mux[4:0]   = 5'(level);
            rd_mux[8]     = empty;
            rd_mux[9]     = full;
            rd_mux[10]    = ovf;
            rd_mux[20:16] = cnt;
        end else if (sel_data) begin
            if (!empty) rd_mux = mem[rd_ptr[AW-1:0]];
        end else if (sel_bitcnt) begin
            rd_mux = bitcnt;
        end
    end

    // Capture FSM, shift register, counters, FIFO pointers and registered read data
    always_ff @(posedge i_CLK_SYS or posedge i_RST_SYS) begin
        if (i_RST_SYS) begin
            state   <= IDLE;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            bitcnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_RDATA <= '0;
        end else begin
            if (i_RDEn) o_RDATA <= rd_mux;
            if (wr_ctrl) begin
                state  <= i_WRDATA[0] ? CAPTURE : IDLE;
                irq_en <= i_WRDATA[3];
            end
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                sr     <= '0;
                cnt    <= '0;
                bitcnt <= '0;
                ovf    <= 1'b0;
            end else begin
                // Clearing sr after a push keeps flushed partial words zero-filled below the data
                if (push) begin
                    sr  <= '0;
                    cnt <= '0;
                end else begin
                    sr  <= sr_shift;
                    cnt <= cnt_next;
                end
                if (shift && bitcnt != 32'hFFFF_FFFF) bitcnt <= bitcnt + 32'd1;
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (push && !push_ok) ovf <= 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed since pointers gate visibility
    always_ff @(posedge i_CLK_SYS) begin
        if (push_ok && !clr) mem[wr_ptr[AW-1:0]] <= sr_shift;
    end

endmodule

// File: tb/tb_fi_chain_reader.sv
// tb/tb_fi_chain_reader.sv - directed self-checking bench for fi_chain_reader
module tb_fi_chain_reader;

    localparam logic [31:0] A_CTRL   = 32'h0000_0100;
    localparam logic [31:0] A_STATUS = 32'h0000_0104;
    localparam logic [31:0] A_DATA   = 32'h0000_0108;
    localparam logic [31:0] A_BITCNT = 32'h0000_010C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        so = 1'b0;
    logic        en_sr = 1'b0;
    logic [31:0] addr = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] wrdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [31:0] rv;
    logic [31:0] w;

    fi_chain_reader #(.BASE_ADDR(32'h0000_0100), .FIFO_DEPTH(8)) dut (
        .i_CLK_SYS(clk),
        .i_RST_SYS(rst),
        .i_SO(so),
        .i_EN_SR(en_sr),
        .i_ADDR(addr),
        .i_WREn(wren),
        .i_RDEn(rden),
        .i_WRDATA(wrdata),
        .o_RDATA(rdata),
        .o_IRQ(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wren = 1'b1; addr = a; wrdata = d;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rden = 1'b1; addr = a;
        @(negedge clk);
        rden = 1'b0;
        d = rdata;
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_sr = 1'b1; so = v[i];
        end
        @(negedge clk);
        en_sr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        bus_read(A_STATUS, rv); check("rst_status", rv, 32'h0000_0100);
        bus_read(A_CTRL, rv);   check("rst_ctrl", rv, 32'h0);

        // simultaneous write and read of CTRL returns the old contents
        @(negedge clk);
        wren = 1'b1; rden = 1'b1; addr = A_CTRL; wrdata = 32'h9;
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        check("wr_rd_same", rdata, 32'h0);
        bus_read(A_CTRL, rv); check("ctrl_after_wr", rv, 32'h9);

        // single word LSB-first
        shift_bits(32'hA5A5_3C3C, 32);
        check("irq_on", {31'b0, irq}, 32'h1);
        bus_read(A_STATUS, rv); check("one_status", rv, 32'h0000_0001);
        bus_read(A_BITCNT, rv); check("one_bitcnt", rv, 32'd32);
        bus_read(A_DATA, rv);   check("one_data", rv, 32'hA5A5_3C3C);
        check("irq_off", {31'b0, irq}, 32'h0);
        bus_read(A_STATUS, rv); check("one_empty", rv, 32'h0000_0100);

        // register window edges
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        bus_read(A_STATUS, rv); check("ro_status", rv, 32'h0000_0100);
        bus_read(32'h0000_0110, rv); check("unmapped", rv, 32'h0);

        // overflow with nine words into an eight-deep FIFO
        for (int k = 0; k < 9; k++) shift_bits(32'hC0DE_0000 + 32'(k), 32);
        bus_read(A_STATUS, rv); check("ovf_status", rv, 32'h0000_0608);
        for (int k = 0; k < 8; k++) begin
            bus_read(A_DATA, rv); check($sformatf("ovf_data%0d", k), rv, 32'hC0DE_0000 + 32'(k));
        end
        bus_read(A_STATUS, rv); check("ovf_sticky", rv, 32'h0000_0500);
        bus_read(A_DATA, rv);   check("empty_read", rv, 32'h0);
        bus_read(A_STATUS, rv); check("empty_read_state", rv, 32'h0000_0500);

        // CLR keeps CAP_EN and IRQ_EN, self-clears
        bus_write(A_CTRL, 32'hB);
        bus_read(A_STATUS, rv); check("clr_status", rv, 32'h0000_0100);
        bus_read(A_BITCNT, rv); check("clr_bitcnt", rv, 32'h0);
        bus_read(A_CTRL, rv);   check("clr_ctrl", rv, 32'h9);

        // partial word flush: bits 1,0,1,1,1
        shift_bits(32'h0000_001D, 5);
        bus_read(A_STATUS, rv); check("part_status", rv, 32'h0005_0100);
        bus_write(A_CTRL, 32'hD);
        bus_read(A_DATA, rv);   check("flush_data", rv, 32'hE800_0000);
        bus_read(A_STATUS, rv); check("flush_status", rv, 32'h0000_0100);
        bus_write(A_CTRL, 32'hD);
        bus_read(A_STATUS, rv); check("flush_zero", rv, 32'h0000_0100);

        // pop and push together while full
        for (int k = 0; k < 8; k++) shift_bits(32'h5A00_0000 + 32'(k), 32);
        w = 32'hFEED_F00D;
        shift_bits(w, 31);
        @(negedge clk);
        en_sr = 1'b1; so = w[31]; rden = 1'b1; addr = A_DATA;
        @(negedge clk);
        en_sr = 1'b0; rden = 1'b0;
        check("pp_data0", rdata, 32'h5A00_0000);
        bus_read(A_STATUS, rv); check("pp_status", rv, 32'h0000_0208);
        for (int k = 1; k < 8; k++) begin
            bus_read(A_DATA, rv); check($sformatf("pp_data%0d", k), rv, 32'h5A00_0000 + 32'(k));
        end
        bus_read(A_DATA, rv); check("pp_last", rv, 32'hFEED_F00D);

        // reset in flight with data queued and a shift active
        shift_bits(32'h7777_7777, 32);
        shift_bits(32'h0001_FFFF, 16);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        en_sr = 1'b1; so = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        en_sr = 1'b0; rst = 1'b0;
        bus_read(A_CTRL, rv);   check("post_rst_ctrl", rv, 32'h0);
        bus_read(A_STATUS, rv); check("post_rst_status", rv, 32'h0000_0100);
        bus_read(A_BITCNT, rv); check("post_rst_bitcnt", rv, 32'h0);
        bus_write(A_CTRL, 32'h1);
        shift_bits(32'h1234_5678, 32);
        bus_read(A_STATUS, rv); check("fresh_status", rv, 32'h0000_0001);
        bus_read(A_DATA, rv);   check("fresh_data", rv, 32'h1234_5678);

        // shifts ignored in IDLE
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            en_sr = i[0]; so = 1'b1;
        end
        @(negedge clk);
        en_sr = 1'b0;
        bus_read(A_BITCNT, rv); check("idle_bitcnt", rv, 32'd32);
        bus_write(A_CTRL, 32'h2);
        bus_read(A_BITCNT, rv); check("idle_clr_bitcnt", rv, 32'h0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            en_sr = i[0]; so = 1'b1;
        end
        @(negedge clk);
        en_sr = 1'b0;
        bus_read(A_BITCNT, rv); check("idle_bitcnt0", rv, 32'h0);
        bus_read(A_STATUS, rv); check("idle_status", rv, 32'h0000_0100);

        // CLR wins over the push on the 32nd bit
        bus_write(A_CTRL, 32'h1);
        shift_bits(32'hFFFF_FFFF, 31);
        @(negedge clk);
        en_sr = 1'b1; so = 1'b1; wren = 1'b1; addr = A_CTRL; wrdata = 32'h3;
        @(negedge clk);
        en_sr = 1'b0; wren = 1'b0;
        bus_read(A_STATUS, rv); check("clr_push_status", rv, 32'h0000_0100);
        bus_read(A_BITCNT, rv); check("clr_push_bitcnt", rv, 32'h0);
        bus_read(A_CTRL, rv);   check("clr_push_ctrl", rv, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fi_chain_reader.md
FI_CHAIN_READER -- requirements
Module: fi_chain_reader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0100, giving the base of its four-word register window.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the capture FIFO depth in 32-bit words (power of two, 2..16).
REQ-003 The block SHALL have port i_CLK_SYS, input, 1 bit: single system clock, rising edge.
REQ-004 The block SHALL have port i_RST_SYS, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_SO, input, 1 bit: serial output of the fault-injection scan chain.
REQ-006 The block SHALL have port i_EN_SR, input, 1 bit: chain shift enable from the controller; i_SO is valid on cycles where it is high.
REQ-007 The block SHALL have port i_ADDR, input, 32 bits: bus byte address.
REQ-008 The block SHALL have port i_WREn, input, 1 bit: bus write strobe.
REQ-009 The block SHALL have port i_RDEn, input, 1 bit: bus read strobe.
REQ-010 The block SHALL have port i_WRDATA, input, 32 bits: bus write data.
REQ-011 The block SHALL have port o_RDATA, output, 32 bits: registered bus read data.
REQ-012 The block SHALL have port o_IRQ, output, 1 bit: level interrupt, high when the FIFO is non-empty and CTRL.IRQ_EN=1.

Function
REQ-013 The register map SHALL be: BASE+0x0 CTRL (RW), BASE+0x4 STATUS (RO), BASE+0x8 DATA (RO, read pops), BASE+0xC BITCNT (RO).
REQ-014 CTRL SHALL contain bit0 CAP_EN, bit1 CLR (self-clearing, reads 0), bit2 FLUSH (self-clearing, reads 0), and bit3 IRQ_EN.
REQ-015 STATUS SHALL contain [4:0] FIFO level, bit8 EMPTY, bit9 FULL, bit10 OVF (sticky), and [20:16] partial bit count.
REQ-016 The FSM SHALL have state IDLE (CAP_EN=0, shifts ignored) and state CAPTURE (CAP_EN=1); the transition SHALL take effect on the cycle after the CTRL write.
REQ-017 In CAPTURE, on each cycle with i_EN_SR=1, the block SHALL set sr <= {i_SO, sr[31:1]}, increment the 5-bit bit counter, and increment BITCNT (saturating at 32'hFFFF_FFFF).
REQ-018 The first serial bit of each 32-bit group SHALL land in bit0 of the pushed word (LSB-first).
REQ-019 When the bit counter wraps 31->0, the word {i_SO, sr[31:1]} SHALL be pushed into the FIFO in the same clock edge.
REQ-020 A push while FULL SHALL drop the word and set OVF, and bit capture SHALL continue.
REQ-021 A simultaneous push and pop while FULL SHALL accept the push, set no OVF, and leave the level unchanged.
REQ-022 A DATA read (i_RDEn at BASE+0x8) SHALL return the FIFO head on o_RDATA one cycle later and pop the head.
REQ-023 A DATA read while EMPTY SHALL return 0 and change no state.
REQ-024 FLUSH with bit count n>0 SHALL push sr as-is (received bits in sr[31:32-n], lower bits 0) and zero the bit counter; FLUSH with n=0 SHALL do nothing.
REQ-025 FLUSH SHALL obey the FULL/OVF rules of REQ-020.
REQ-026 CLR SHALL empty the FIFO, zero sr, the bit counter, BITCNT and OVF, and leave CAP_EN and IRQ_EN unchanged.
REQ-027 CLR SHALL take priority over a shift, push or pop occurring in the same cycle.
REQ-028 All reads SHALL have 1-cycle latency, and o_RDATA SHALL hold its last value when i_RDEn=0.
REQ-029 Reads of unmapped addresses SHALL return 0.
REQ-030 Writes to STATUS, DATA, BITCNT or unmapped addresses SHALL be ignored.
REQ-031 Simultaneous i_WREn and i_RDEn SHALL perform both operations, and the read SHALL return pre-write contents.

Reset
REQ-032 Asserting i_RST_SYS SHALL immediately force IDLE, CTRL=0, empty FIFO, sr=0, bit counter=0, BITCNT=0, OVF=0, o_RDATA=0 and o_IRQ=0, including mid-shift or mid-read.
REQ-033 Captured data SHALL NOT survive reset, and the first capture after reset release SHALL begin at bit0 of a fresh word.

Verification
REQ-034 Enable capture and shift 32 bits of 32'hA5A5_3C3C LSB-first -> STATUS level=1, a DATA read returns 32'hA5A5_3C3C, then EMPTY=1.
REQ-035 With FIFO_DEPTH=8, shift 9*32 bits without reading -> FULL=1, OVF=1, level=8, and the first 8 words read back in order.
REQ-036 Shift 5 bits 1,0,1,1,1, then write FLUSH -> DATA reads 32'hE800_0000 and partial count=0.
REQ-037 With FULL, a DATA read and the 32nd bit in the same cycle -> level stays 8, OVF=0, and the new word is last out.
REQ-038 Assert i_RST_SYS after 17 bits in flight -> all outputs 0; after release, 32 new bits give exactly one intact word.
REQ-039 Keep CAP_EN=0 with i_EN_SR toggling for 64 cycles -> BITCNT=0 and EMPTY=1; then CLR during a push cycle -> FIFO empty and BITCNT=0.
